kmer_signature_gen: RTL and testbench
=====================================

KMER_SIGNATURE_GEN -- requirements
Module: kmer_signature_gen

Interface
REQ-001 The block SHALL expose parameter SIGNATURE_WIDTH, default 32, meaning signature width and k-mer register width (KMER_LEN = SIGNATURE_WIDTH/2 bases).
REQ-002 The block SHALL expose parameter INDEX_WIDTH, default 10, meaning k-mer index width.
REQ-003 The block SHALL expose parameter HASH_MULT, default 32'h9E3779B1, meaning the odd multiplicative hash constant.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1, meaning begin a new sequence (accepted only in IDLE).
REQ-007 The block SHALL have port base_valid, input, 1, meaning base is offered this cycle.
REQ-008 The block SHALL have port base, input, 2, meaning nucleotide code A=0, C=1, G=2, T=3.
REQ-009 The block SHALL have port base_last, input, 1, meaning the offered base is the final base of the sequence.
REQ-010 The block SHALL have port base_ready, output, 1, meaning the block accepts a base this cycle.
REQ-011 The block SHALL have port valid_out, output, 1, meaning one-cycle pulse qualifying signature_out/index_out; it drives the sorter's valid_in.
REQ-012 The block SHALL have port signature_out, output, SIGNATURE_WIDTH, meaning the hashed k-mer signature.
REQ-013 The block SHALL have port index_out, output, INDEX_WIDTH, meaning the 0-based k-mer index within the sequence.
REQ-014 The block SHALL have port seq_done, output, 1, meaning one-cycle pulse marking end of sequence output.
REQ-015 The block SHALL have port overflow, output, 1, meaning sticky flag: k-mers were dropped because the index space was exhausted.

Function
REQ-016 A base SHALL be accepted when base_valid && base_ready on a rising clk edge.
REQ-017 The FSM SHALL have states IDLE, FILL, STREAM, DRAIN; base_ready SHALL be 1 only in FILL and STREAM.
REQ-018 IDLE -> FILL on start=1; start SHALL clear the k-mer register, the fill counter, the index counter and overflow.
REQ-019 On each accepted base the k-mer register SHALL shift left by 2 with base inserted at bits [1:0].
REQ-020 FILL SHALL count accepted bases; on the KMER_LEN-th accepted base it SHALL go to STREAM, and that base SHALL produce k-mer index 0.
REQ-021 In STREAM every accepted base SHALL produce one k-mer, and the index SHALL increment by 1 per k-mer.
REQ-022 An accepted base with base_last=1 (FILL or STREAM) SHALL move to DRAIN; if it occurs in FILL before KMER_LEN bases, no k-mer SHALL be emitted for the sequence.
REQ-023 The hash SHALL be mix = low SIGNATURE_WIDTH bits of (kmer * HASH_MULT), and signature = mix XOR (mix >> 15).
REQ-024 The hash SHALL be a 2-stage pipeline; valid_out SHALL assert exactly 2 cycles after the accepting edge of the k-mer's last base.
REQ-025 DRAIN SHALL wait until the pipeline is empty, pulse seq_done for one cycle (the cycle after the final valid_out, or 2 cycles after entry if none), and then return to IDLE.
REQ-026 The k-mer with index 2^INDEX_WIDTH-1 SHALL be the last one emitted; later k-mers SHALL be suppressed (no valid_out) and overflow SHALL be set, with base acceptance continuing.
REQ-027 start outside IDLE SHALL be ignored, and base_valid in IDLE or DRAIN SHALL be ignored.
REQ-028 The block SHALL have no downstream backpressure: valid_out SHALL be a single-cycle pulse per k-mer, with at most one per cycle.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, base_ready=0, valid_out=0, seq_done=0, overflow=0, signature_out=0, index_out=0, clear the pipeline valids, the k-mer register and the counters.
REQ-030 Reset asserted mid-sequence SHALL discard in-flight k-mers; no valid_out or seq_done SHALL follow its release.

Verification
REQ-031 A bench SHALL cover: start, then 16 bases of A (0) -> one valid_out 2 cycles after the 16th base, signature 0x00000000, index 0; then seq_done.
REQ-032 A bench SHALL cover: start, then 16 bases of T (3) with base_last on the 16th -> signature 0x61C845DE, index 0; seq_done the next cycle.
REQ-033 A bench SHALL cover: a 20-base stream without gaps -> 5 consecutive valid_out pulses with indices 0..4 on back-to-back cycles.
REQ-034 A bench SHALL cover: a 10-base sequence with base_last -> no valid_out; seq_done 2 cycles after entering DRAIN.
REQ-035 A bench SHALL cover: INDEX_WIDTH=2 with 20 bases -> indices 0..3 emitted, the 5th k-mer suppressed, overflow=1 until the next start.
REQ-036 A bench SHALL cover: rst_n pulsed low 1 cycle after the 16th base -> no valid_out, state IDLE, all outputs 0.

Source files
------------

// File: rtl/kmer_signature_gen.sv
// kmer_signature_gen: turns a stream of 2-bit nucleotide codes into one hashed
// signature per overlapping k-mer (KMER_LEN = SIGNATURE_WIDTH/2 bases), with a
// 0-based index, an end-of-sequence pulse and a sticky index-overflow flag.
`timescale 1ns/1ps
module kmer_signature_gen #(
    parameter int                         SIGNATURE_WIDTH = 32,
    parameter int                         INDEX_WIDTH     = 10,
    parameter logic [SIGNATURE_WIDTH-1:0] HASH_MULT       = 32'h9E3779B1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       base_valid,
    input  logic [1:0]                 base,
    input  logic                       base_last,
    output logic                       base_ready,
    output logic                       valid_out,
    output logic [SIGNATURE_WIDTH-1:0] signature_out,
    output logic [INDEX_WIDTH-1:0]     index_out,
    output logic                       seq_done,
    output logic                       overflow
);

    localparam int KMER_LEN = SIGNATURE_WIDTH / 2;
    localparam int FILL_W   = (KMER_LEN > 1) ? $clog2(KMER_LEN) : 1;
    localparam logic [FILL_W-1:0]      FILL_LAST = FILL_W'(KMER_LEN - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_MAX   = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    // Multiplicative mix, keeping only the low SIGNATURE_WIDTH bits.
    function automatic logic [SIGNATURE_WIDTH-1:0] f_mix(input logic [SIGNATURE_WIDTH-1:0] kmer);
        logic [SIGNATURE_WIDTH-1:0] prod;
        prod = kmer * HASH_MULT;
        return prod;
    endfunction

    // Fold high bits down so the low signature bits depend on the whole k-mer.
    function automatic logic [SIGNATURE_WIDTH-1:0] f_fold(input logic [SIGNATURE_WIDTH-1:0] mix);
        return mix ^ (mix >> 15);
    endfunction

    logic [1:0]                 r_state;
    logic [SIGNATURE_WIDTH-1:0] r_kmer_p0;
    logic [FILL_W-1:0]          r_fill_cnt;
    logic [INDEX_WIDTH-1:0]     r_idx_cnt;
    logic                       r_idx_full;
    logic                       r_overflow;
    logic                       r_drain_first;
    logic                       r_seq_done;
    logic                       r_vld_p0;
    logic                       r_vld_p1;
    logic                       r_vld_p2;
    logic [INDEX_WIDTH-1:0]     r_idx_p0;
    logic [INDEX_WIDTH-1:0]     r_idx_p1;
    logic [INDEX_WIDTH-1:0]     r_idx_p2;
    logic [SIGNATURE_WIDTH-1:0] r_mix_p1;
    logic [SIGNATURE_WIDTH-1:0] r_sig_p2;

    logic                       w_ready;
    logic                       w_accept;
    logic                       w_kmer_ok;
    logic                       w_emit;
    logic                       w_pipe_empty;
    logic [SIGNATURE_WIDTH-1:0] w_kmer_next;

    assign w_ready      = (r_state == S_FILL) || (r_state == S_STREAM);
    assign w_accept     = base_valid && w_ready;
    // A complete k-mer exists on every accepted base in STREAM and on the
    // KMER_LEN-th accepted base in FILL.
    assign w_kmer_ok    = w_accept && ((r_state == S_STREAM) ||
                                       ((r_state == S_FILL) && (r_fill_cnt == FILL_LAST)));
    // Once the last index has been handed out, further k-mers are dropped.
    assign w_emit       = w_kmer_ok && !r_idx_full;
    assign w_pipe_empty = !r_vld_p0 && !r_vld_p1;
    assign w_kmer_next  = {r_kmer_p0[SIGNATURE_WIDTH-3:0], base};

    // Sequencer: FSM, k-mer shift register, fill/index counters, overflow and end pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_kmer_p0     <= '0;
            r_fill_cnt    <= '0;
            r_idx_cnt     <= '0;
            r_idx_full    <= 1'b0;
            r_overflow    <= 1'b0;
            r_drain_first <= 1'b0;
            r_seq_done    <= 1'b0;
        end else begin
            r_seq_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_kmer_p0  <= '0;
                        r_fill_cnt <= '0;
                        r_idx_cnt  <= '0;
                        r_idx_full <= 1'b0;
                        r_overflow <= 1'b0;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL, S_STREAM: begin
                    if (w_accept) begin
                        r_kmer_p0 <= w_kmer_next;
                        if (r_state == S_FILL) begin
                            r_fill_cnt <= r_fill_cnt + 1'b1;
                        end
                        if (w_kmer_ok) begin
                            if (r_idx_full) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_idx_cnt <= r_idx_cnt + 1'b1;
                                if (r_idx_cnt == IDX_MAX) begin
                                    r_idx_full <= 1'b1;
                                end
                            end
                        end
                        if (base_last) begin
                            r_state       <= S_DRAIN;
                            r_drain_first <= 1'b1;
                        end else if ((r_state == S_FILL) && (r_fill_cnt == FILL_LAST)) begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                default: begin
                    // The first DRAIN cycle always waits so an empty sequence
                    // still ends two cycles after entry.
                    r_drain_first <= 1'b0;
                    if (!r_drain_first && w_pipe_empty) begin
                        r_seq_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Valid pipeline travelling alongside the hash data; reset drops in-flight k-mers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p0 <= w_emit;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // Stage p0 -> p1: index capture and multiplicative mix.
    always_ff @(posedge clk) begin
        if (w_emit) begin
            r_idx_p0 <= r_idx_cnt;
        end
        if (r_vld_p0) begin
            r_mix_p1 <= f_mix(r_kmer_p0);
            r_idx_p1 <= r_idx_p0;
        end
    end

    // Stage p1 -> p2: fold and register the visible outputs (held between pulses).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_p2 <= '0;
            r_idx_p2 <= '0;
        end else if (r_vld_p1) begin
            r_sig_p2 <= f_fold(r_mix_p1);
            r_idx_p2 <= r_idx_p1;
        end
    end

    assign base_ready    = w_ready;
    assign valid_out     = r_vld_p2;
    assign signature_out = r_sig_p2;
    assign index_out     = r_idx_p2;
    assign seq_done      = r_seq_done;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_kmer_signature_gen.sv
// tb_kmer_signature_gen: directed and random sequences against a reference
// model that hashes every window of 16 bases with plain arithmetic.
`timescale 1ns/1ps
module tb_kmer_signature_gen;

    localparam int KL = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        base_valid;
    logic [1:0]  base;
    logic        base_last;

    logic        a_ready, a_vo, a_sd, a_ovf;
    logic [31:0] a_sig;
    logic [9:0]  a_idx;
    logic        b_ready, b_vo, b_sd, b_ovf;
    logic [31:0] b_sig;
    logic [1:0]  b_idx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          a_ev_cyc[$], a_ev_idx[$], a_sd_cyc[$];
    logic [31:0] a_ev_sig[$];
    int          b_ev_cyc[$], b_ev_idx[$], b_sd_cyc[$];
    logic [31:0] b_ev_sig[$];
    int          acc_edge[$];
    logic [1:0]  b_q[$];

    kmer_signature_gen #(.SIGNATURE_WIDTH(32), .INDEX_WIDTH(10), .HASH_MULT(32'h9E3779B1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .base_valid(base_valid), .base(base),
        .base_last(base_last), .base_ready(a_ready), .valid_out(a_vo), .signature_out(a_sig),
        .index_out(a_idx), .seq_done(a_sd), .overflow(a_ovf));

    kmer_signature_gen #(.SIGNATURE_WIDTH(32), .INDEX_WIDTH(2), .HASH_MULT(32'h9E3779B1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .base_valid(base_valid), .base(base),
        .base_last(base_last), .base_ready(b_ready), .valid_out(b_vo), .signature_out(b_sig),
        .index_out(b_idx), .seq_done(b_sd), .overflow(b_ovf));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_vo) begin
            a_ev_cyc.push_back(cyc);
            a_ev_sig.push_back(a_sig);
            a_ev_idx.push_back(int'(a_idx));
        end
        if (a_sd) a_sd_cyc.push_back(cyc);
        if (b_vo) begin
            b_ev_cyc.push_back(cyc);
            b_ev_sig.push_back(b_sig);
            b_ev_idx.push_back(int'(b_idx));
        end
        if (b_sd) b_sd_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_sig(input int first);
        longint unsigned kmer, mix;
        kmer = 0;
        for (int j = first; j < first + KL; j++) kmer = ((kmer << 2) | longint'(b_q[j])) & 64'hFFFF_FFFF;
        mix = (kmer * 64'h9E3779B1) & 64'hFFFF_FFFF;
        return 32'(mix ^ (mix >> 15));
    endfunction

    task automatic clear_logs();
        a_ev_cyc.delete(); a_ev_sig.delete(); a_ev_idx.delete(); a_sd_cyc.delete();
        b_ev_cyc.delete(); b_ev_sig.delete(); b_ev_idx.delete(); b_sd_cyc.delete();
        acc_edge.delete(); b_q.delete();
    endtask

    // pat < 0 gives random bases, otherwise every base equals pat.
    task automatic run_seq(input int n, input int pat, input bit do_last);
        bit all_ready;
        logic [1:0] b;
        clear_logs();
        all_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = (pat < 0) ? 2'($urandom_range(0, 3)) : 2'(pat);
            b_q.push_back(b);
            base_valid = 1'b1;
            base       = b;
            base_last  = do_last && (i == n - 1);
            if (!a_ready) all_ready = 1'b0;
            @(posedge clk); #1;
            acc_edge.push_back(cyc);
            @(negedge clk);
        end
        base_valid = 1'b0;
        base_last  = 1'b0;
        chk("base_ready_during_seq", longint'(all_ready), 1);
        if (do_last) begin
            for (int k = 0; k < 12 && a_sd_cyc.size() == 0; k++) @(negedge clk);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_dut(input string tag, input int iw, input int ev_cyc[$],
                             input logic [31:0] ev_sig[$], input int ev_idx[$],
                             input int sd_cyc[$], input logic ovf);
        int nk, ne, n, last_v, exp_sd;
        n  = b_q.size();
        nk = (n >= KL) ? n - KL + 1 : 0;
        ne = (nk > (1 << iw)) ? (1 << iw) : nk;
        chk({tag, "_count"}, ev_cyc.size(), ne);
        for (int e = 0; e < ne && e < ev_cyc.size(); e++) begin
            chk({tag, "_cycle"}, ev_cyc[e], acc_edge[e + KL - 1] + 2);
            chk({tag, "_sig"}, ev_sig[e], ref_sig(e));
            chk({tag, "_idx"}, ev_idx[e], e);
        end
        exp_sd = acc_edge[n - 1] + 2;
        if (ne > 0) begin
            last_v = acc_edge[ne - 1 + KL - 1] + 2;
            if (last_v + 1 > exp_sd) exp_sd = last_v + 1;
        end
        chk({tag, "_seqdone_count"}, sd_cyc.size(), 1);
        if (sd_cyc.size() > 0) chk({tag, "_seqdone_cycle"}, sd_cyc[0], exp_sd);
        chk({tag, "_overflow"}, longint'(ovf), longint'(nk > (1 << iw)));
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ready"}, a_ready, 0);
        chk({tag, "_valid"}, a_vo, 0);
        chk({tag, "_seqdone"}, a_sd, 0);
        chk({tag, "_overflow"}, a_ovf, 0);
        chk({tag, "_sig"}, a_sig, 0);
        chk({tag, "_idx"}, a_idx, 0);
        chk({tag, "_b_overflow"}, b_ovf, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_valid = 1'b0; base = 2'd0; base_last = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 16 x A: signature of the all-zero k-mer
        run_seq(16, 0, 1'b1);
        check_dut("allA", 10, a_ev_cyc, a_ev_sig, a_ev_idx, a_sd_cyc, a_ovf);
        if (a_ev_sig.size() > 0) chk("allA_const_sig", a_ev_sig[0], 32'h0000_0000);

        // 16 x T with base_last on the 16th
        run_seq(16, 3, 1'b1);
        check_dut("allT", 10, a_ev_cyc, a_ev_sig, a_ev_idx, a_sd_cyc, a_ovf);
        if (a_ev_sig.size() > 0) chk("allT_const_sig", a_ev_sig[0], 32'h61C8_45DE);

        // 20 random bases: 5 k-mers back to back; narrow-index instance overflows
        run_seq(20, -1, 1'b1);
        check_dut("s20", 10, a_ev_cyc, a_ev_sig, a_ev_idx, a_sd_cyc, a_ovf);
        check_dut("s20_iw2", 2, b_ev_cyc, b_ev_sig, b_ev_idx, b_sd_cyc, b_ovf);
        chk("s20_iw2_ovf_held", b_ovf, 1);

        // 10 bases: too short for any k-mer; start also clears overflow
        run_seq(10, -1, 1'b1);
        check_dut("short10", 10, a_ev_cyc, a_ev_sig, a_ev_idx, a_sd_cyc, a_ovf);
        check_dut("short10_iw2", 2, b_ev_cyc, b_ev_sig, b_ev_idx, b_sd_cyc, b_ovf);

        // random lengths
        for (int t = 0; t < 4; t++) begin
            run_seq(int'($urandom_range(14, 40)), -1, 1'b1);
            check_dut("rnd", 10, a_ev_cyc, a_ev_sig, a_ev_idx, a_sd_cyc, a_ovf);
            check_dut("rnd_iw2", 2, b_ev_cyc, b_ev_sig, b_ev_idx, b_sd_cyc, b_ovf);
        end

        // reset pulse one cycle after the 16th base discards the in-flight k-mer
        run_seq(16, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle_zero("midreset_low");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_idle_zero("midreset_after");
        chk("midreset_no_valid", a_ev_cyc.size() + b_ev_cyc.size(), 0);
        chk("midreset_no_seqdone", a_sd_cyc.size() + b_sd_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
